// File: rtl/mem_req_arbiter.sv
// Arbiter between icache and dcache for the shared byte-serial RAM engine.
// Dcache has priority; icache is granted after STARVE_LIMIT consecutive dcache grants.
module mem_req_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  icache_valid,
    input  logic [ADDR_WIDTH-1:0] icache_addr,
    output logic                  icache_done,
    output logic [DATA_WIDTH-1:0] icache_rdata,
    input  logic                  dcache_valid,
    input  logic [ADDR_WIDTH-1:0] dcache_addr,
    input  logic [DATA_WIDTH-1:0] dcache_wdata,
    input  logic                  dcache_wr,
    input  logic [1:0]            dcache_size,
    output logic                  dcache_done,
    output logic [DATA_WIDTH-1:0] dcache_rdata,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wr,
    output logic [1:0]            mem_size,
    input  logic                  mem_done,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [1:0]            state_q, state_d;
    logic [2:0]            starve_q, starve_d;
    logic [1:0]            owner_q, owner_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [1:0]            mem_size_q, mem_size_d;
    logic                  icache_done_q, icache_done_d;
    logic [DATA_WIDTH-1:0] icache_rdata_q, icache_rdata_d;
    logic                  dcache_done_q, dcache_done_d;
    logic [DATA_WIDTH-1:0] dcache_rdata_q, dcache_rdata_d;

    logic                  pick_i;
    logic [DATA_WIDTH-1:0] rdata_ext;

    // Engine handshake: the request transfers on a cycle where mem_valid and
    // mem_ready are both 1; mem_valid and payload hold until then. mem_done is
    // a single-cycle completion, sampled only after the request has transferred.
    always_comb begin
        pick_i = icache_valid && (!dcache_valid || (starve_q == LIMIT));
        case (mem_size_q)
            2'd0:    rdata_ext = {{(DATA_WIDTH-8){1'b0}}, mem_rdata[7:0]};
            2'd1:    rdata_ext = {{(DATA_WIDTH-16){1'b0}}, mem_rdata[15:0]};
            default: rdata_ext = mem_rdata;
        endcase
        if (mem_wr_q) begin
            rdata_ext = '0;
        end
    end

    always_comb begin
        state_d        = state_q;
        starve_d       = starve_q;
        owner_d        = owner_q;
        mem_valid_d    = mem_valid_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wr_d       = mem_wr_q;
        mem_size_d     = mem_size_q;
        icache_done_d  = icache_done_q;
        icache_rdata_d = icache_rdata_q;
        dcache_done_d  = dcache_done_q;
        dcache_rdata_d = dcache_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (icache_valid || dcache_valid) begin
                    if (pick_i) begin
                        owner_d     = OWN_I;
                        mem_addr_d  = icache_addr;
                        mem_wdata_d = '0;
                        mem_wr_d    = 1'b0;
                        mem_size_d  = 2'd2;
                        starve_d    = '0;
                    end else begin
                        owner_d     = OWN_D;
                        mem_addr_d  = dcache_addr;
                        mem_wdata_d = dcache_wdata;
                        mem_wr_d    = dcache_wr;
                        mem_size_d  = dcache_size;
                        // Count only dcache grants that made a waiting icache wait longer.
                        if (!icache_valid) begin
                            starve_d = '0;
                        end else if (starve_q != LIMIT) begin
                            starve_d = starve_q + 3'd1;
                        end
                    end
                    mem_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    if (owner_q == OWN_I) begin
                        icache_done_d  = 1'b1;
                        icache_rdata_d = rdata_ext;
                    end else begin
                        dcache_done_d  = 1'b1;
                        dcache_rdata_d = rdata_ext;
                    end
                    state_d = S_RESP;
                end
            end
            default: begin
                icache_done_d  = 1'b0;
                icache_rdata_d = '0;
                dcache_done_d  = 1'b0;
                dcache_rdata_d = '0;
                owner_d        = OWN_NONE;
                state_d        = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            starve_q       <= '0;
            owner_q        <= OWN_NONE;
            mem_valid_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_wr_q       <= 1'b0;
            mem_size_q     <= '0;
            icache_done_q  <= 1'b0;
            icache_rdata_q <= '0;
            dcache_done_q  <= 1'b0;
            dcache_rdata_q <= '0;
        end else if (rdy) begin
            state_q        <= state_d;
            starve_q       <= starve_d;
            owner_q        <= owner_d;
            mem_valid_q    <= mem_valid_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wr_q       <= mem_wr_d;
            mem_size_q     <= mem_size_d;
            icache_done_q  <= icache_done_d;
            icache_rdata_q <= icache_rdata_d;
            dcache_done_q  <= dcache_done_d;
            dcache_rdata_q <= dcache_rdata_d;
        end
    end

    assign icache_done  = icache_done_q;
    assign icache_rdata = icache_rdata_q;
    assign dcache_done  = dcache_done_q;
    assign dcache_rdata = dcache_rdata_q;
    assign mem_valid    = mem_valid_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wr       = mem_wr_q;
    assign mem_size     = mem_size_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed vectors, corner sequences, and a
// randomized run against a transaction-level arbitration model.
module tb_mem_req_arbiter;

    localparam int LIMIT = 4;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        icache_valid = 1'b0;
    logic [31:0] icache_addr = '0;
    logic        dcache_valid = 1'b0;
    logic [31:0] dcache_addr = '0;
    logic [31:0] dcache_wdata = '0;
    logic        dcache_wr = 1'b0;
    logic [1:0]  dcache_size = '0;
    logic        mem_ready = 1'b0;
    logic        mem_done = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        icache_done, dcache_done, mem_valid, mem_wr;
    logic [31:0] icache_rdata, dcache_rdata, mem_addr, mem_wdata;
    logic [1:0]  mem_size, dbg_state;

    mem_req_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .icache_valid(icache_valid), .icache_addr(icache_addr),
        .icache_done(icache_done), .icache_rdata(icache_rdata),
        .dcache_valid(dcache_valid), .dcache_addr(dcache_addr),
        .dcache_wdata(dcache_wdata), .dcache_wr(dcache_wr), .dcache_size(dcache_size),
        .dcache_done(dcache_done), .dcache_rdata(dcache_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    bit          grant_q[$];

    wire [135:0] outs = {dbg_state, mem_valid, mem_addr, mem_wdata, mem_wr, mem_size,
                         icache_done, icache_rdata, dcache_done, dcache_rdata};

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          ddly;
        logic [31:0] exp_wdata;
        bit          exp_wr;
        logic [1:0]  exp_size;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read data as the requester should see it: writes return 0, reads keep
    // the low byte, low half or full word.
    function automatic logic [31:0] ext_ref(input logic [31:0] rd, input bit wr, input logic [1:0] sz);
        if (wr) return 32'h0;
        if (sz == 2'd0) return rd % 32'd256;
        if (sz == 2'd1) return rd % 32'd65536;
        return rd;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        rdy = 1'b1;
        icache_valid = 1'b0;
        dcache_valid = 1'b0;
        mem_ready = 1'b0;
        mem_done = 1'b0;
        tick();
        check("reset_outputs", 160'(outs), 160'(0));
        rst = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        if (v.is_d) begin
            dcache_valid = 1'b1;
            dcache_addr = v.addr;
            dcache_wdata = v.wdata;
            dcache_wr = v.wr;
            dcache_size = v.size;
        end else begin
            icache_valid = 1'b1;
            icache_addr = v.addr;
            dcache_wdata = v.wdata;
        end
        tick();
        check("vec_grant", 160'({dbg_state, mem_valid}), 160'({S_ISSUE, 1'b1}));
        check("vec_payload", 160'({mem_addr, mem_wdata, mem_wr, mem_size}),
              160'({v.addr, v.exp_wdata, v.exp_wr, v.exp_size}));
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("vec_accept", 160'({dbg_state, mem_valid}), 160'({S_WAIT, 1'b0}));
        repeat (v.ddly) tick();
        check("vec_wait", 160'({dbg_state, icache_done, dcache_done}), 160'({S_WAIT, 2'b00}));
        mem_done = 1'b1;
        mem_rdata = v.mrdata;
        tick();
        mem_done = 1'b0;
        mem_rdata = $urandom;
        check("vec_done", 160'({icache_done, dcache_done}), 160'(v.is_d ? 2'b01 : 2'b10));
        check("vec_rdata", 160'(v.is_d ? dcache_rdata : icache_rdata), 160'(v.exp_rdata));
        check("vec_other_rdata", 160'(v.is_d ? icache_rdata : dcache_rdata), 160'(0));
        icache_valid = 1'b0;
        dcache_valid = 1'b0;
        tick();
        check("vec_done_clear", 160'({dbg_state, icache_done, dcache_done}), 160'({S_IDLE, 2'b00}));
    endtask

    // Acts as both requesters and the engine, one slot per clock. Grants are
    // predicted from the inputs that were on the pins at the granting edge.
    task automatic run_random(input int ncyc, input int p_req, input bit wild);
        int eng = 0;
        int rcnt = 0;
        int dcnt = 0;
        int stall = 0;
        int consec = 0;
        bit own_d = 1'b0;
        bit exp_done;
        bit i_pend = 1'b0;
        bit d_pend = 1'b0;
        bit s_iv, s_dv, s_rdy, s_dwr;
        logic [31:0] s_ia, s_da, s_dw;
        logic [1:0]  s_dsz;
        logic [66:0] pay = '0;
        logic [135:0] snap;
        snap = outs;
        for (int c = 0; c < ncyc + 400; c++) begin
            s_iv = icache_valid; s_dv = dcache_valid; s_rdy = rdy;
            s_ia = icache_addr; s_da = dcache_addr; s_dw = dcache_wdata;
            s_dwr = dcache_wr; s_dsz = dcache_size;
            tick();
            if (c >= ncyc && !i_pend && !d_pend && eng == 0) break;
            if (!s_rdy) begin
                check("freeze", 160'(outs), 160'(snap));
            end else begin
                exp_done = 1'b0;
                case (eng)
                    0: if (mem_valid) begin
                        check("grant_has_req", 160'(s_iv | s_dv), 160'(1));
                        own_d = !(s_iv && (!s_dv || consec == LIMIT));
                        if (!own_d || !s_iv) consec = 0;
                        else if (consec < LIMIT) consec++;
                        grant_q.push_back(own_d);
                        pay = own_d ? {s_da, s_dw, s_dwr, s_dsz} : {s_ia, 32'h0, 1'b0, 2'd2};
                        check("grant_payload", 160'({mem_addr, mem_wdata, mem_wr, mem_size}), 160'(pay));
                        eng = 1;
                        rcnt = wild ? int'($urandom_range(0, 3)) : 0;
                    end
                    1: if (mem_ready) begin
                        check("issue_drop", 160'(mem_valid), 160'(0));
                        mem_ready = 1'b0;
                        eng = 2;
                        dcnt = wild ? int'($urandom_range(0, 3)) : 0;
                    end else begin
                        check("issue_hold", 160'({mem_valid, mem_addr, mem_wdata, mem_wr, mem_size}),
                              160'({1'b1, pay}));
                    end
                    2: if (mem_done) begin
                        exp_done = 1'b1;
                        mem_done = 1'b0;
                        eng = 0;
                    end
                    default: ;
                endcase
                if (eng == 1 && !mem_ready) begin
                    if (rcnt == 0) mem_ready = 1'b1;
                    else rcnt--;
                end
                if (eng == 2 && !mem_done) begin
                    if (dcnt == 0) begin
                        mem_done = 1'b1;
                        mem_rdata = $urandom;
                        exp_q.push_back(ext_ref(mem_rdata, pay[2], pay[1:0]));
                    end else dcnt--;
                end
                if (exp_done) begin
                    check("done_owner", 160'({icache_done, dcache_done}), 160'(own_d ? 2'b01 : 2'b10));
                    check("done_rdata", 160'(own_d ? dcache_rdata : icache_rdata), 160'(exp_q.pop_front()));
                    check("nonowner_rdata", 160'(own_d ? icache_rdata : dcache_rdata), 160'(0));
                    if (own_d) begin d_pend = 1'b0; dcache_valid = 1'b0; end
                    else begin i_pend = 1'b0; icache_valid = 1'b0; end
                    stall = 0;
                end else begin
                    check("no_done", 160'({icache_done, dcache_done}), 160'(0));
                end
                if (c < ncyc) begin
                    if (!i_pend && $urandom_range(0, 99) < p_req) begin
                        i_pend = 1'b1; icache_valid = 1'b1; icache_addr = $urandom;
                    end
                    if (!d_pend && $urandom_range(0, 99) < p_req) begin
                        d_pend = 1'b1; dcache_valid = 1'b1; dcache_addr = $urandom;
                        dcache_wdata = $urandom; dcache_wr = 1'($urandom); dcache_size = 2'($urandom);
                    end
                end
                if (wild && $urandom_range(0, 3) == 0) icache_addr = $urandom;
                if (wild && $urandom_range(0, 3) == 0) dcache_addr = $urandom;
                stall++;
                if (stall > 100) begin
                    check("progress_timeout", 160'(1), 160'(0));
                    break;
                end
            end
            if (wild) rdy = ($urandom_range(0, 9) > 2);
            snap = outs;
        end
        rdy = 1'b1;
        check("drained", 160'({i_pend, d_pend, eng != 0}), 160'(0));
    endtask

    initial begin
        bit [9:0] order;
        vecs[0] = '{0, 0, 2'd0, 32'h0000_2000, 32'h9999_0000, 32'hDEAD_BEEF, 3, 32'h0, 0, 2'd2, 32'hDEAD_BEEF};
        vecs[1] = '{1, 0, 2'd0, 32'h0000_0013, 32'h1234_5678, 32'hAABB_CCDD, 0, 32'h1234_5678, 0, 2'd0, 32'h0000_00DD};
        vecs[2] = '{1, 0, 2'd1, 32'h0000_0012, 32'h0, 32'hAABB_CCDD, 1, 32'h0, 0, 2'd1, 32'h0000_CCDD};
        vecs[3] = '{1, 1, 2'd2, 32'h0000_0040, 32'h1122_3344, 32'hFFFF_FFFF, 0, 32'h1122_3344, 1, 2'd2, 32'h0};
        vecs[4] = '{1, 0, 2'd3, 32'h0000_0080, 32'h0, 32'h1234_5678, 2, 32'h0, 0, 2'd3, 32'h1234_5678};
        vecs[5] = '{1, 1, 2'd0, 32'h0000_0007, 32'h0000_00A5, 32'h0000_FFFF, 0, 32'h0000_00A5, 1, 2'd0, 32'h0};

        do_reset();
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset while waiting for the engine abandons the transaction.
        do_reset();
        dcache_valid = 1'b1; dcache_addr = 32'h100; dcache_wr = 1'b0; dcache_size = 2'd2;
        tick();
        check("rst_wait_grant", 160'({dbg_state, mem_addr}), 160'({S_ISSUE, 32'h100}));
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("rst_wait_state", 160'(dbg_state), 160'(S_WAIT));
        rst = 1'b0; dcache_valid = 1'b0;
        tick();
        check("rst_wait_outputs", 160'(outs), 160'(0));
        rst = 1'b1; mem_done = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_done = 1'b0;
        check("rst_late_done1", 160'({dbg_state, icache_done, dcache_done}), 160'({S_IDLE, 2'b00}));
        tick();
        check("rst_late_done2", 160'({dbg_state, icache_done, dcache_done}), 160'({S_IDLE, 2'b00}));

        // rdy=0 freezes an ISSUE even though the engine is ready.
        do_reset();
        icache_valid = 1'b1; icache_addr = 32'h3000;
        tick();
        check("frz_grant", 160'(mem_valid), 160'(1));
        rdy = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("frz_hold", 160'({dbg_state, mem_valid, mem_addr}), 160'({S_ISSUE, 1'b1, 32'h3000}));
        end
        rdy = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("frz_accept", 160'({dbg_state, mem_valid}), 160'({S_WAIT, 1'b0}));
        mem_done = 1'b1; mem_rdata = 32'h55;
        tick();
        mem_done = 1'b0;
        check("frz_done", 160'({icache_done, icache_rdata}), 160'({1'b1, 32'h55}));
        icache_valid = 1'b0;
        tick();

        // Slow engine: payload held, requester address changes and stray
        // mem_done pulses during ISSUE have no effect.
        do_reset();
        icache_valid = 1'b1; icache_addr = 32'h4000;
        tick();
        for (int i = 0; i < 10; i++) begin
            icache_addr = $urandom;
            mem_done = (i == 3);
            tick();
            check("slow_hold", 160'({dbg_state, mem_valid, mem_addr, mem_wr, mem_size, icache_done}),
                  160'({S_ISSUE, 1'b1, 32'h4000, 1'b0, 2'd2, 1'b0}));
        end
        mem_done = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; mem_done = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_done = 1'b0;
        check("slow_done", 160'({icache_done, icache_rdata}), 160'({1'b1, 32'h0BAD_F00D}));
        icache_valid = 1'b0;
        tick();

        // Both requesters always pending: four dcache grants, then one icache.
        do_reset();
        grant_q.delete();
        run_random(80, 100, 1'b0);
        check("starve_count", 160'(grant_q.size() >= 10), 160'(1));
        order = '0;
        for (int i = 0; i < 10 && i < grant_q.size(); i++) order[i] = grant_q[i];
        check("starve_order", 160'(order), 160'(10'b0111101111));

        do_reset();
        run_random(1500, 30, 1'b1);
        do_reset();
        run_random(1500, 80, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
